mac_tap_sequencer: RTL and testbench

Drives a `MAC` instance as a TAPS-tap FIR engine for the nyq datapath. It accepts one sample per valid/ready handshake and shifts it into a sample delay line. It then streams delay-line/coefficient operand pairs into the MAC with the correct `Clr`/`WrEn` framing, captures the MAC's combinational result on the last tap, and presents it on a valid/ready output port. Coefficients live in a local register file written over a simple write port.

---
 rtl/mac_tap_sequencer.sv | 138 +++++++++++++
 tb/tb_mac_tap_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mac_tap_sequencer.sv
// FIR tap sequencer: feeds a shared MAC one delay-line/coefficient pair per cycle.
// Define MAC_SEQ_SYMMETRIC_EN to fold the delay line for linear-phase (even TAPS) filters.
module mac_tap_sequencer #(
  parameter int WIDTH = 16,
  parameter int TAPS  = 8
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RI,
  input  logic                     InValid_SI,
  output logic                     InReady_SO,
  input  logic [WIDTH-1:0]         In_DI,
  input  logic                     CoefWrEn_SI,
  input  logic [$clog2(TAPS)-1:0]  CoefAddr_DI,
  input  logic [WIDTH-1:0]         Coef_DI,
  output logic                     MacClr_SO,
  output logic                     MacWrEn_SO,
  output logic [WIDTH-1:0]         MacIn0_DO,
  output logic [WIDTH-1:0]         MacIn1_DO,
  input  logic [WIDTH-1:0]         MacOut_DI,
  output logic                     OutValid_SO,
  input  logic                     OutReady_SI,
  output logic [WIDTH-1:0]         Out_DO
);

`ifdef MAC_SEQ_SYMMETRIC_EN
  localparam int NT = TAPS / 2;
`else
  localparam int NT = TAPS;
`endif
  localparam int AW = $clog2(TAPS);
  localparam int CW = (NT > 1) ? $clog2(NT) : 1;
  localparam logic [AW:0]   NT_L   = (AW+1)'(NT);
  localparam logic [CW-1:0] LAST_K = CW'(NT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    tap_q, tap_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dl_q   [TAPS];
  logic [WIDTH-1:0] coef_q [NT];

  logic             accept;
  logic             coef_we;
  logic [NT-1:0]    coef_hit;
  logic [AW-1:0]    dl_idx;
  logic [WIDTH-1:0] tap_operand;

  assign dl_idx = AW'(tap_q);

`ifdef MAC_SEQ_SYMMETRIC_EN
  // Pre-add mirrored taps at WIDTH+1 bits; dropping the LSB is a floor shift.
  logic [AW-1:0] mir_idx;
  logic [WIDTH:0] pair_sum;
  assign mir_idx     = AW'(TAPS - 1) - dl_idx;
  assign pair_sum    = {dl_q[dl_idx][WIDTH-1], dl_q[dl_idx]}
                     + {dl_q[mir_idx][WIDTH-1], dl_q[mir_idx]};
  assign tap_operand = pair_sum[WIDTH:1];
`else
  assign tap_operand = dl_q[dl_idx];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_coef_hit
      assign coef_hit[gi] = coef_we && (CoefAddr_DI == AW'(gi));
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    out_d       = out_q;
    accept      = 1'b0;
    coef_we     = 1'b0;
    InReady_SO  = 1'b0;
    OutValid_SO = 1'b0;
    MacClr_SO   = 1'b0;
    MacWrEn_SO  = 1'b0;
    MacIn0_DO   = '0;
    MacIn1_DO   = '0;
    // Reset silences every handshake and MAC strobe even when caught mid-sum.
    if (!Rst_RI) begin
      case (state_q)
        IDLE: begin
          InReady_SO = 1'b1;
          accept     = InValid_SI;
          coef_we    = CoefWrEn_SI && ({1'b0, CoefAddr_DI} < NT_L);
          if (accept) begin
            tap_d   = '0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          MacWrEn_SO = 1'b1;
          MacClr_SO  = (tap_q == '0);
          MacIn0_DO  = tap_operand;
          MacIn1_DO  = coef_q[tap_q];
          if (tap_q == LAST_K) begin
            out_d   = MacOut_DI;
            state_d = HOLD;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
        HOLD: begin
          OutValid_SO = 1'b1;
          if (OutReady_SI) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= IDLE;
      tap_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < TAPS; i++) dl_q[i] <= '0;
      for (int i = 0; i < NT; i++) coef_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      out_q   <= out_d;
      if (accept) begin
        dl_q[0] <= In_DI;
        for (int i = 1; i < TAPS; i++) dl_q[i] <= dl_q[i-1];
      end
      for (int i = 0; i < NT; i++) begin
        if (coef_hit[i]) coef_q[i] <= Coef_DI;
      end
    end
  end

  assign Out_DO = out_q;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Directed bench for mac_tap_sequencer with a behavioural MAC attached (WIDTH=16, TAPS=4).
module tb_mac_tap_sequencer;
  localparam int W = 16;
  localparam int T = 4;
`ifdef MAC_SEQ_SYMMETRIC_EN
  localparam int NT_EXP = T / 2;
`else
  localparam int NT_EXP = T;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, cwe, mac_clr, mac_wren, out_valid, out_ready;
  logic [W-1:0] in_data, cdata, mac_in0, mac_in1, mac_out, out_data;
  logic [1:0]   caddr;

  mac_tap_sequencer #(.WIDTH(W), .TAPS(T)) dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .InValid_SI(in_valid), .InReady_SO(in_ready), .In_DI(in_data),
    .CoefWrEn_SI(cwe), .CoefAddr_DI(caddr), .Coef_DI(cdata),
    .MacClr_SO(mac_clr), .MacWrEn_SO(mac_wren),
    .MacIn0_DO(mac_in0), .MacIn1_DO(mac_in1), .MacOut_DI(mac_out),
    .OutValid_SO(out_valid), .OutReady_SI(out_ready), .Out_DO(out_data)
  );

  // Behavioural MAC: Q1.15 product bits [30:15] added to the running sum.
  logic [W-1:0]        acc_q;
  logic signed [2*W-1:0] prod;
  assign prod    = $signed(mac_in0) * $signed(mac_in1);
  assign mac_out = (mac_clr ? '0 : acc_q) + prod[2*W-2:W-1];
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else if (mac_wren) acc_q <= mac_out;
  end

  int wren_cnt = 0;
  always_ff @(posedge clk) if (mac_wren) wren_cnt <= wren_cnt + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic coef_write(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk); cwe = 1'b1; caddr = a; cdata = d;
    @(negedge clk); cwe = 1'b0;
  endtask

  // One sample through the filter; optionally tries coefficient writes in ACCUM and HOLD.
  task automatic run_sample(input logic [W-1:0] x, input logic [W-1:0] exp,
                            input string tag, input bit wr_mid);
    int n;
    int c0;
    @(negedge clk); in_valid = 1'b1; in_data = x;
    c0 = wren_cnt;
    @(negedge clk); in_valid = 1'b0;
    if (wr_mid) begin cwe = 1'b1; caddr = 2'd2; cdata = '0; end
    @(negedge clk); cwe = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, " valid"}, out_valid, 1);
    check(tag, out_data, exp);
    check({tag, " wren_cycles"}, wren_cnt - c0, NT_EXP);
    $display("[TB] %s in=%h out=%h", tag, x, out_data);
    out_ready = 1'b1;
    if (wr_mid) begin cwe = 1'b1; caddr = 2'd1; cdata = '0; end
    @(negedge clk); out_ready = 1'b0; cwe = 1'b0;
  endtask

  initial begin
    int n;
    logic [W-1:0] imp_in  [5] = '{16'h2000, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [W-1:0] imp_exp [5] = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0};
    logic [W-1:0] dc_exp  [5] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h4000};
    logic [W-1:0] fl_exp  [4] = '{16'h3000, 16'h2000, 16'h1000, 16'h0};
    logic [W-1:0] sym_exp [4] = '{16'h0800, 16'h0, 16'h0, 16'h0800};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; cwe = 1'b0; caddr = '0; cdata = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst wren", mac_wren, 0);
    check("rst clr", mac_clr, 0);
    rst = 1'b0;
    #1 check("post_rst in_ready", in_ready, 1);

`ifdef MAC_SEQ_SYMMETRIC_EN
    coef_write(2'd0, 16'h4000);
    coef_write(2'd1, 16'h0000);
    for (int i = 0; i < 4; i++)
      run_sample(imp_in[i], sym_exp[i], $sformatf("sym%0d", i), 1'b0);
`else
    for (int i = 0; i < 4; i++) coef_write(2'(i), 16'h4000);

    for (int i = 0; i < 5; i++)
      run_sample(imp_in[i], imp_exp[i], $sformatf("imp%0d", i), 1'b0);
    for (int i = 0; i < 5; i++)
      run_sample(16'h2000, dc_exp[i], $sformatf("dc%0d", i), 1'b0);

    // Cycle framing: accept at edge 0, observe cycles 1..5 at the negedge.
    @(negedge clk); in_valid = 1'b1; in_data = 16'h2000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      check($sformatf("frame clr c%0d", c), mac_clr, (c == 1));
      check($sformatf("frame wren c%0d", c), mac_wren, (c <= 4));
      check($sformatf("frame ovalid c%0d", c), out_valid, (c >= 5));
      check($sformatf("frame iready c%0d", c), in_ready, 0);
    end
    check("frame out", out_data, 16'h4000);
    $display("[TB] frame out=%h", out_data);

    // Backpressure: result held, a waiting sample must not be taken.
    in_valid = 1'b1; in_data = 16'h7000;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      check($sformatf("bp ovalid %0d", b), out_valid, 1);
      check($sformatf("bp out %0d", b), out_data, 16'h4000);
      check($sformatf("bp iready %0d", b), in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    run_sample(16'h2000, 16'h4000, "bp_noaccept", 1'b0);

    for (int i = 0; i < 4; i++)
      run_sample(16'h0, fl_exp[i], $sformatf("flush%0d", i), 1'b0);

    // Coefficient write coincident with sample accept is used by that sum.
    @(negedge clk); in_valid = 1'b1; in_data = 16'h2000;
    cwe = 1'b1; caddr = 2'd0; cdata = 16'h2000;
    @(negedge clk); in_valid = 1'b0; cwe = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("simul valid", out_valid, 1);
    check("simul out", out_data, 16'h0800);
    $display("[TB] simul in=2000 out=%h", out_data);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    coef_write(2'd0, 16'h4000);
    for (int i = 0; i < 4; i++)
      run_sample(16'h0, imp_exp[i + 1 > 3 ? 4 : i], $sformatf("drain%0d", i), 1'b0);

    // Writes attempted in ACCUM/HOLD must not disturb the coefficients.
    for (int i = 0; i < 4; i++)
      run_sample(imp_in[i], imp_exp[i], $sformatf("cwmid%0d", i), 1'b1);

    // Reset at tap 2 clears coefficients; next impulse yields zero.
    @(negedge clk); in_valid = 1'b1; in_data = 16'h2000;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst wren_before", mac_wren, 1);
    rst = 1'b1;
    #1;
    check("midrst wren", mac_wren, 0);
    check("midrst clr", mac_clr, 0);
    check("midrst iready", in_ready, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("midrst iready_after", in_ready, 1);
    check("midrst ovalid", out_valid, 0);
    check("midrst out", out_data, 0);
    run_sample(16'h2000, 16'h0, "post_midrst", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
